// File: rtl/serial_adder_ctrl_if.sv
// rtl/serial_adder_ctrl_if.sv - request/result bundle for the bit-serial adder controller
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder: one full adder reused LSB-first over WIDTH cycles
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);
  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus
);
  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             load, step, finish;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s_bit, c_bit;
  logic [WIDTH-1:0] res_cat;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  full_adder u_fa (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Cin  (carry),
    .Sum  (s_bit),
    .Cout (c_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign finish = step && (cnt == LAST);

  // Only the earlier WIDTH-1 sum bits need storage; the last bit goes straight to sum.
  generate
    if (WIDTH == 1) begin : g_w1
      assign res_cat = s_bit;
    end else begin : g_wn
      logic [WIDTH-2:0] res_sh;
      assign res_cat = {s_bit, res_sh};
      always_ff @(posedge clk or posedge rst) begin
        if (rst)       res_sh <= '0;
        else if (step) res_sh <= res_cat[WIDTH-1:1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      a_sh  <= bus.a;
      b_sh  <= bus.b;
      carry <= bus.cin;
      cnt   <= '0;
    end else if (step) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= c_bit;
      cnt   <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (finish) begin
      sum_q  <= res_cat;
      cout_q <= c_bit;
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard bench for serial_adder_ctrl at WIDTH 8 and WIDTH 1
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [8:0] q8[$];
  logic [1:0] q1[$];

  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always @(negedge clk) begin
    if (bus8.done === 1'b1) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL w8_unexpected_done: got %h/%b, required none", bus8.sum, bus8.cout);
      end else begin
        logic [8:0] exp8;
        exp8 = q8.pop_front();
        if ({bus8.cout, bus8.sum} !== exp8) begin
          errors++;
          $display("FAIL w8_result: got %h, required %h", {bus8.cout, bus8.sum}, exp8);
        end
      end
    end
    if (bus1.done === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL w1_unexpected_done: got %b%b, required none", bus1.cout, bus1.sum);
      end else begin
        logic [1:0] exp1;
        exp1 = q1.pop_front();
        if ({bus1.cout, bus1.sum} !== exp1) begin
          errors++;
          $display("FAIL w1_result: got %b, required %b", {bus1.cout, bus1.sum}, exp1);
        end
      end
    end
  end

  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic c);
    bus8.a = a; bus8.b = b; bus8.cin = c; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    q8.push_back(9'(a) + 9'(b) + 9'(c));
    bus8.a = ~a; bus8.b = ~b; bus8.cin = ~c;
  endtask

  task automatic wait_done8();
    int cyc = 0;
    while (bus8.done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (bus8.done !== 1'b1) begin
      errors++;
      $display("FAIL w8_done_timeout: done=%b after %0d cycles, required 1", bus8.done, cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if ({bus8.busy, bus8.done, bus8.cout, bus8.sum} !== 11'h0 ||
        {bus1.busy, bus1.done, bus1.cout, bus1.sum} !== 4'h0) begin
      errors++;
      $display("FAIL reset_power_up: w8=%b%b%b%h w1=%b%b%b%b, required all 0",
               bus8.busy, bus8.done, bus8.cout, bus8.sum, bus1.busy, bus1.done, bus1.cout, bus1.sum);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    launch8(8'h7F, 8'h01, 1'b0);
    wait_done8();
    @(posedge clk); #4;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus8.busy, bus8.done, bus8.cout, bus8.sum} !== 11'h0) begin
      errors++;
      $display("FAIL reset_async: busy=%b done=%b cout=%b sum=%h, required all 0",
               bus8.busy, bus8.done, bus8.cout, bus8.sum);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_latency();
    launch8(8'hFF, 8'h01, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) begin
        errors++;
        $display("FAIL latency_busy cycle %0d: busy=%b done=%b, required 1/0", i, bus8.busy, bus8.done);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bus8.done !== 1'b1 || bus8.busy !== 1'b0) begin
      errors++;
      $display("FAIL latency_done: done=%b busy=%b, required 1/0", bus8.done, bus8.busy);
    end
    @(posedge clk); #1;
    checks++;
    if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b busy=%b, required 0/0", bus8.done, bus8.busy);
    end
  endtask

  task automatic test_patterns();
    launch8(8'hA5, 8'h5A, 1'b1);
    wait_done8();
    @(posedge clk); #1;
    launch8(8'h12, 8'h34, 1'b0);
    wait_done8();
    repeat (5) begin
      @(posedge clk); #1;
    end
    checks++;
    if (bus8.sum !== 8'h46 || bus8.cout !== 1'b0) begin
      errors++;
      $display("FAIL result_hold: sum=%h cout=%b, required 46/0", bus8.sum, bus8.cout);
    end
  endtask

  task automatic test_ignore_start();
    launch8(8'h0F, 8'h01, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.cin = 1'b1; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    checks++;
    if (bus8.busy !== 1'b1 || bus8.sum !== 8'h46) begin
      errors++;
      $display("FAIL ignore_mid_run: busy=%b sum=%h, required 1/46", bus8.busy, bus8.sum);
    end
    wait_done8();
    @(posedge clk); #1;
    checks++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_no_rerun: busy=%b done=%b, required 0/0", bus8.busy, bus8.done);
    end
  endtask

  task automatic test_back_to_back();
    bus8.a = 8'h01; bus8.b = 8'h02; bus8.cin = 1'b0; bus8.start = 1'b1;
    @(posedge clk); #1;
    q8.push_back(9'h003);
    bus8.a = 8'h55; bus8.b = 8'hAA; bus8.cin = 1'b1;
    wait_done8();
    checks++;
    if (bus8.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_exclusive: busy=%b with done, required 0", bus8.busy);
    end
    bus8.a = 8'h80; bus8.b = 8'h80; bus8.cin = 1'b0;
    q8.push_back(9'h100);
    @(posedge clk); #1;
    bus8.start = 1'b0;
    checks++;
    if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_gap: busy=%b done=%b, required 1/0", bus8.busy, bus8.done);
    end
    wait_done8();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    launch8(8'hFF, 8'h01, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.sum !== 8'h00 || bus8.cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b done=%b sum=%h cout=%b, required 0/0/00/0",
               bus8.busy, bus8.done, bus8.sum, bus8.cout);
    end
    q8.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    launch8(8'h01, 8'h01, 1'b0);
    wait_done8();
    @(posedge clk); #1;
  endtask

  task automatic test_width1();
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      bus1.a = v[2]; bus1.b = v[1]; bus1.cin = v[0]; bus1.start = 1'b1;
      @(posedge clk); #1;
      bus1.start = 1'b0;
      q1.push_back(2'(v[2]) + 2'(v[1]) + 2'(v[0]));
      checks++;
      if (bus1.busy !== 1'b1 || bus1.done !== 1'b0) begin
        errors++;
        $display("FAIL w1_busy combo %0d: busy=%b done=%b, required 1/0", i, bus1.busy, bus1.done);
      end
      @(posedge clk); #1;
      checks++;
      if (bus1.done !== 1'b1 || bus1.busy !== 1'b0) begin
        errors++;
        $display("FAIL w1_done combo %0d: done=%b busy=%b, required 1/0", i, bus1.done, bus1.busy);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
    test_reset();
    test_latency();
    test_patterns();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_width1();
    repeat (2) @(posedge clk);
    checks++;
    if (q8.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: w8 pending=%0d w1 pending=%0d, required 0/0", q8.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
